// File: rtl/fma16.sv
// fma16: combinational binary16 fused multiply-add with IEEE flags.
// Only state is the sticky flag accumulator.
module fma16 (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] z,
    input  logic        mul,
    input  logic        add,
    input  logic        negp,
    input  logic        negz,
    input  logic [1:0]  roundmode,
    output logic [15:0] result,
    output logic [3:0]  flags,
    output logic [3:0]  flags_sticky
);

    localparam logic [1:0] RZ  = 2'b00;
    localparam logic [1:0] RNE = 2'b01;
    localparam logic [1:0] RDN = 2'b10;
    localparam logic [1:0] RUP = 2'b11;

    function automatic logic is_nan(input logic [15:0] v);
        return (&v[14:10]) && (|v[9:0]);
    endfunction

    function automatic logic is_inf(input logic [15:0] v);
        return (&v[14:10]) && !(|v[9:0]);
    endfunction

    function automatic logic is_zero(input logic [15:0] v);
        return !(|v[14:0]);
    endfunction

    function automatic logic [10:0] sig(input logic [15:0] v);
        return {|v[14:10], v[9:0]};
    endfunction

    function automatic logic [6:0] expo(input logic [15:0] v);
        return (v[14:10] == 5'd0) ? 7'd1 : {2'b00, v[14:10]};
    endfunction

    logic [15:0] yv;
    logic [15:0] zv;
    logic        anynan;
    logic        pinf;
    logic        zinf;
    logic        inv_mul;
    logic        inv_add;
    logic        invalid;
    logic        ps;
    logic        zs;
    logic        sub;

    assign yv = mul ? y : 16'h3C00;
    assign zv = add ? z : 16'h0000;

    assign anynan  = is_nan(x) | is_nan(yv) | is_nan(zv);
    assign pinf    = is_inf(x) | is_inf(yv);
    assign zinf    = is_inf(zv);
    assign inv_mul = (is_inf(x) & is_zero(yv)) | (is_zero(x) & is_inf(yv));
    assign ps      = x[15] ^ yv[15] ^ negp;
    assign zs      = zv[15] ^ negz;
    assign sub     = ps ^ zs;
    assign inv_add = pinf & zinf & sub;
    assign invalid = anynan | inv_mul | inv_add;

    // Exact fixed-point field, LSB weight 2^-48, covers every product and addend.
    logic [21:0] psig;
    logic [6:0]  pshift;
    logic [6:0]  zshift;
    logic [81:0] pm;
    logic [81:0] zm;
    logic        pge;
    logic [81:0] mag;
    logic        sgn;
    logic        zsign;

    assign psig   = sig(x) * sig(yv);
    assign pshift = expo(x) + expo(yv) - 7'd2;
    assign zshift = expo(zv) + 7'd23;
    assign pm     = 82'(psig) << pshift;
    assign zm     = 82'(sig(zv)) << zshift;
    assign pge    = pm >= zm;
    assign mag    = !sub ? pm + zm : (pge ? pm - zm : zm - pm);
    assign sgn    = (!sub || pge) ? ps : zs;
    assign zsign  = (!add || !sub) ? ps : (roundmode == RDN);

    logic [6:0] lead;

    always_comb begin
        lead = 7'd0;
        for (int i = 0; i < 82; i++) begin
            if (mag[i]) lead = 7'(i);
        end
    end

    // Below the normal range the kept LSB is pinned at 2^-24.
    logic [6:0]  s;
    logic [81:0] lower;
    logic [81:0] half;
    logic        rbit;
    logic        stk;
    logic        inx;
    logic [11:0] q;
    logic        inc;
    logic [11:0] qr;
    logic [17:0] pk;
    logic        ovf;
    logic        tiny;
    logic        tomax;

    assign s     = (lead > 7'd34) ? lead - 7'd10 : 7'd24;
    assign lower = mag & ~({82{1'b1}} << s);
    assign half  = 82'(1) << (s - 7'd1);
    assign rbit  = |(lower & half);
    assign stk   = |(lower & (half - 82'(1)));
    assign inx   = rbit | stk;
    assign q     = 12'(mag >> s);

    always_comb begin
        inc = 1'b0;
        unique case (roundmode)
            RZ:  inc = 1'b0;
            RNE: inc = rbit & (stk | q[0]);
            RDN: inc = sgn & inx;
            RUP: inc = !sgn & inx;
        endcase
    end

    // Implicit bit of q carries into the exponent field when added.
    assign qr    = q + {11'd0, inc};
    assign pk    = ({11'd0, s - 7'd24} << 10) + {6'd0, qr};
    assign ovf   = pk >= 18'h7C00;
    assign tiny  = pk < 18'h0400;
    assign tomax = (roundmode == RZ)
                 | ((roundmode == RUP) & sgn)
                 | ((roundmode == RDN) & !sgn);

    always_comb begin
        result = 16'h0000;
        flags  = 4'b0000;
        unique case (1'b1)
            invalid: begin
                result = 16'h7E00;
                flags  = 4'b1000;
            end
            !invalid && pinf: begin
                result = {ps, 15'h7C00};
            end
            !invalid && !pinf && zinf: begin
                result = {zs, 15'h7C00};
            end
            !invalid && !pinf && !zinf && (mag == 82'd0): begin
                result = {zsign, 15'h0000};
            end
            !invalid && !pinf && !zinf && (mag != 82'd0) && ovf: begin
                result = {sgn, tomax ? 15'h7BFF : 15'h7C00};
                flags  = 4'b0101;
            end
            default: begin
                result = {sgn, pk[14:0]};
                flags  = {2'b00, tiny & inx, inx};
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_sticky <= 4'b0000;
        end else begin
            flags_sticky <= flags_sticky | flags;
        end
    end

endmodule

// File: tb/tb_fma16.sv
// tb_fma16: directed vectors with hand-computed binary16 results.
// Covers add/mul/fma paths, rounding modes, specials, subnormals, sticky.
module tb_fma16;

    logic        clk;
    logic        reset;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic        mul;
    logic        add;
    logic        negp;
    logic        negz;
    logic [1:0]  roundmode;
    logic [15:0] result;
    logic [3:0]  flags;
    logic [3:0]  flags_sticky;

    int checks;
    int failures;

    fma16 dut (
        .clk(clk),
        .reset(reset),
        .x(x),
        .y(y),
        .z(z),
        .mul(mul),
        .add(add),
        .negp(negp),
        .negz(negz),
        .roundmode(roundmode),
        .result(result),
        .flags(flags),
        .flags_sticky(flags_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic m,
                         input logic ad, input logic np, input logic nz,
                         input logic [1:0] rm);
        x = a;
        y = b;
        z = c;
        mul = m;
        add = ad;
        negp = np;
        negz = nz;
        roundmode = rm;
    endtask

    task automatic vec(input string tag, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] c,
                       input logic m, input logic ad, input logic np,
                       input logic nz, input logic [1:0] rm,
                       input logic [15:0] er, input logic [3:0] ef);
        drive(a, b, c, m, ad, np, nz, rm);
        #1;
        chk({tag, ".res"}, result, er);
        chk({tag, ".flg"}, {12'd0, flags}, {12'd0, ef});
    endtask

    task automatic vres(input string tag, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] c,
                        input logic m, input logic ad, input logic np,
                        input logic nz, input logic [1:0] rm,
                        input logic [15:0] er);
        drive(a, b, c, m, ad, np, nz, rm);
        #1;
        chk({tag, ".res"}, result, er);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        drive(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_sticky", {12'd0, flags_sticky}, 16'h0);

        vec("add1", 16'h3C00, 16'h0, 16'h3C00, 0, 1, 0, 0, 2'b01, 16'h4000, 4'h0);
        vec("canc", 16'h3C00, 16'h0, 16'h3C00, 0, 1, 0, 1, 2'b01, 16'h0000, 4'h0);
        vec("cancd", 16'h3C00, 16'h0, 16'h3C00, 0, 1, 0, 1, 2'b10, 16'h8000, 4'h0);
        vec("mul3", 16'h3E00, 16'h4000, 16'h0, 1, 0, 0, 0, 2'b01, 16'h4200, 4'h0);
        vec("mulrne", 16'h3C01, 16'h3C01, 16'h0, 1, 0, 0, 0, 2'b01, 16'h3C02, 4'h1);
        vec("fma", 16'h4000, 16'h4000, 16'hBC00, 1, 1, 0, 0, 2'b01, 16'h4200, 4'h0);

        vec("rz", 16'h3C01, 16'h3C01, 16'h0, 1, 0, 0, 0, 2'b00, 16'h3C02, 4'h1);
        vec("rdn", 16'h3C01, 16'h3C01, 16'h0, 1, 0, 0, 0, 2'b10, 16'h3C02, 4'h1);
        vec("rup", 16'h3C01, 16'h3C01, 16'h0, 1, 0, 0, 0, 2'b11, 16'h3C03, 4'h1);
        vec("nrz", 16'h3C01, 16'h3C01, 16'h0, 1, 0, 1, 0, 2'b00, 16'hBC02, 4'h1);
        vec("nrdn", 16'h3C01, 16'h3C01, 16'h0, 1, 0, 1, 0, 2'b10, 16'hBC03, 4'h1);
        vec("nrup", 16'h3C01, 16'h3C01, 16'h0, 1, 0, 1, 0, 2'b11, 16'hBC02, 4'h1);
        vec("tie_ev", 16'h3C00, 16'h0, 16'h1000, 0, 1, 0, 0, 2'b01, 16'h3C00, 4'h1);
        vec("tie_od", 16'h3C01, 16'h0, 16'h1000, 0, 1, 0, 0, 2'b01, 16'h3C02, 4'h1);
        vec("tie_up", 16'h3C00, 16'h0, 16'h1000, 0, 1, 0, 0, 2'b11, 16'h3C01, 4'h1);

        vec("ovf_rne", 16'h7BFF, 16'h4000, 16'h0, 1, 0, 0, 0, 2'b01, 16'h7C00, 4'h5);
        vec("ovf_rz", 16'h7BFF, 16'h4000, 16'h0, 1, 0, 0, 0, 2'b00, 16'h7BFF, 4'h5);
        vec("ovf_nup", 16'h7BFF, 16'h4000, 16'h0, 1, 0, 1, 0, 2'b11, 16'hFBFF, 4'h5);
        vec("ovf_ndn", 16'h7BFF, 16'h4000, 16'h0, 1, 0, 1, 0, 2'b10, 16'hFC00, 4'h5);
        vec("ovf_dn", 16'h7BFF, 16'h4000, 16'h0, 1, 0, 0, 0, 2'b10, 16'h7BFF, 4'h5);

        vec("zxinf", 16'h0000, 16'h7C00, 16'h0, 1, 0, 0, 0, 2'b01, 16'h7E00, 4'h8);
        vec("infsub", 16'h7C00, 16'h0, 16'hFC00, 0, 1, 0, 0, 2'b01, 16'h7E00, 4'h8);
        vres("qnan", 16'h7E00, 16'h0, 16'h0, 0, 0, 0, 0, 2'b01, 16'h7E00);
        vec("snan", 16'h3C00, 16'h7D00, 16'h0, 1, 0, 0, 0, 2'b01, 16'h7E00, 4'h8);
        vec("infx1", 16'h7C00, 16'h3C00, 16'h0, 1, 0, 0, 0, 2'b01, 16'h7C00, 4'h0);
        vec("infadd", 16'h3C00, 16'h0, 16'hFC00, 0, 1, 0, 0, 2'b01, 16'hFC00, 4'h0);
        vec("ynan_ign", 16'h3C00, 16'h7E00, 16'h0, 0, 0, 0, 0, 2'b01, 16'h3C00, 4'h0);

        vec("z0_mix", 16'h0000, 16'h0, 16'h8000, 0, 1, 0, 0, 2'b01, 16'h0000, 4'h0);
        vec("z0_mixd", 16'h0000, 16'h0, 16'h8000, 0, 1, 0, 0, 2'b10, 16'h8000, 4'h0);
        vec("z0_neg", 16'h8000, 16'h0, 16'h8000, 0, 1, 0, 0, 2'b01, 16'h8000, 4'h0);
        vec("z0_prod", 16'h8000, 16'h3C00, 16'h0, 1, 0, 0, 0, 2'b01, 16'h8000, 4'h0);

        vec("uflow", 16'h0001, 16'h3800, 16'h0, 1, 0, 0, 0, 2'b01, 16'h0000, 4'h3);
        vec("subex", 16'h0400, 16'h3800, 16'h0, 1, 0, 0, 0, 2'b01, 16'h0200, 4'h0);
        vec("sub_up", 16'h03FF, 16'h3C01, 16'h0, 1, 0, 0, 0, 2'b11, 16'h0400, 4'h1);
        vec("sub_rz", 16'h03FF, 16'h3C01, 16'h0, 1, 0, 0, 0, 2'b00, 16'h03FF, 4'h3);

        // Reset still held: flags seen at edges must not accumulate.
        drive(16'h0001, 16'h3800, 16'h0, 1, 0, 0, 0, 2'b01);
        @(posedge clk);
        #1;
        chk("held_rst", {12'd0, flags_sticky}, 16'h0);

        @(negedge clk);
        drive(16'h3C00, 16'h0, 16'h3C00, 0, 1, 0, 0, 2'b01);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("st_clean", {12'd0, flags_sticky}, 16'h0);

        @(negedge clk);
        drive(16'h0001, 16'h3800, 16'h0, 1, 0, 0, 0, 2'b01);
        @(posedge clk);
        #1;
        chk("st_uf", {12'd0, flags_sticky}, 16'h3);

        @(negedge clk);
        drive(16'h3E00, 16'h4000, 16'h0, 1, 0, 0, 0, 2'b01);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("st_hold", {12'd0, flags_sticky}, 16'h3);

        #1;
        reset = 1'b0;
        #1;
        chk("st_async", {12'd0, flags_sticky}, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
